// File: rtl/nco_ctrl_pkg.sv
// nco_ctrl_pkg: shared types and defaults for the NCO frequency-plan sequencer
// and its helpers.
//   sweep_state_t  : sweep FSM encoding
//   *_DEF          : default widths for step word, dwell counter and step index
//   NCO_ACC_INT/FRAC : split of the NCO phase accumulator the step word feeds
package nco_ctrl_pkg;

  localparam int STEP_WIDTH_DEF  = 32;
  localparam int DWELL_WIDTH_DEF = 24;
  localparam int IDX_WIDTH_DEF   = 16;
  localparam int NCO_ACC_INT     = 8;
  localparam int NCO_ACC_FRAC    = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DWELL = 3'd2,
    ST_NEXT  = 3'd3,
    ST_MUTE  = 3'd4,
    ST_DONE  = 3'd5
  } sweep_state_t;

endpackage

// File: rtl/nco_sweep_ctrl_dwell_timer.sv
// dwell_timer: loadable down-counter that stops at zero.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture value into the counter (has priority over enable)
//   value      : reload value
//   enable     : decrement by one per clock while non-zero
//   expired    : counter currently reads zero
module dwell_timer #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             enable,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: steps the NCO phase increment through a linear frequency plan
// (START..STOP by INC, DWELL clocks per point, single-shot or looping) and
// presents each step word on an AXI-Stream style output.
//   aclk, arst_n          : clock, asynchronous active-low reset
//   cfg_*                 : sweep plan, captured on start and frozen for the sweep
//   start / abort         : single-clock command pulses (abort wins)
//   m_axis_step_*         : step word to the NCO (registered, no tready->tvalid path)
//   busy                  : LOAD/DWELL/NEXT/MUTE
//   done                  : single-clock pulse at the end of a non-looping sweep
//   step_index            : index of the current point, 0 at START
module nco_sweep_ctrl
  import nco_ctrl_pkg::*;
#(
  parameter int STEP_WIDTH  = STEP_WIDTH_DEF,
  parameter int DWELL_WIDTH = DWELL_WIDTH_DEF,
  parameter int IDX_WIDTH   = IDX_WIDTH_DEF
) (
  input  logic                   aclk,
  input  logic                   arst_n,
  input  logic [STEP_WIDTH-1:0]  cfg_start_step,
  input  logic [STEP_WIDTH-1:0]  cfg_stop_step,
  input  logic [STEP_WIDTH-1:0]  cfg_inc_step,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic                   cfg_loop,
  input  logic                   start,
  input  logic                   abort,
  output logic [STEP_WIDTH-1:0]  m_axis_step_tdata,
  output logic                   m_axis_step_tvalid,
  input  logic                   m_axis_step_tready,
  output logic                   busy,
  output logic                   done,
  output logic [IDX_WIDTH-1:0]   step_index
);

  sweep_state_t state_q, state_d;

  logic [STEP_WIDTH-1:0]  start_sh_q, start_sh_d;
  logic [STEP_WIDTH-1:0]  stop_sh_q, stop_sh_d;
  logic [STEP_WIDTH-1:0]  inc_sh_q, inc_sh_d;
  logic [DWELL_WIDTH-1:0] dwell_sh_q, dwell_sh_d;
  logic                   loop_sh_q, loop_sh_d;

  logic [STEP_WIDTH-1:0]  cur_q, cur_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [STEP_WIDTH-1:0]  tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   done_q, done_d;

  logic [STEP_WIDTH:0]    step_sum;
  logic                   overrun;
  logic                   timer_load;
  logic [DWELL_WIDTH-1:0] timer_value;
  logic                   timer_expired;

  // Index counter holds at all-ones rather than wrapping on very long sweeps.
  function automatic logic [IDX_WIDTH-1:0] sat_inc(input logic [IDX_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end
    return v + {{(IDX_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // One extra bit catches wrap-around past the top of the step range, so a
  // sweep near full scale terminates instead of restarting from a low tone.
  assign step_sum = {1'b0, cur_q} + {1'b0, inc_sh_q};
  assign overrun  = step_sum[STEP_WIDTH] || (step_sum[STEP_WIDTH-1:0] > stop_sh_q);

  // Timer is armed on the accepting handshake; DWELL=0 behaves like DWELL=1.
  assign timer_load  = (state_q == ST_LOAD) && m_axis_step_tready;
  assign timer_value = (dwell_sh_q == '0) ? '0
                     : dwell_sh_q - {{(DWELL_WIDTH-1){1'b0}}, 1'b1};

  dwell_timer #(
    .WIDTH (DWELL_WIDTH)
  ) u_dwell_timer (
    .clk     (aclk),
    .rst_n   (arst_n),
    .load    (timer_load),
    .value   (timer_value),
    .enable  (state_q == ST_DWELL),
    .expired (timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    start_sh_d = start_sh_q;
    stop_sh_d  = stop_sh_q;
    inc_sh_d   = inc_sh_q;
    dwell_sh_d = dwell_sh_q;
    loop_sh_d  = loop_sh_q;
    cur_d      = cur_q;
    idx_d      = idx_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    done_d     = 1'b0;

    if (abort && (state_q != ST_IDLE) && (state_q != ST_MUTE)) begin
      // Mute: hand the NCO a zero step so the tone stops.
      state_d  = ST_MUTE;
      tdata_d  = '0;
      tvalid_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start && !abort) begin
            start_sh_d = cfg_start_step;
            stop_sh_d  = cfg_stop_step;
            inc_sh_d   = cfg_inc_step;
            dwell_sh_d = cfg_dwell;
            loop_sh_d  = cfg_loop;
            cur_d      = cfg_start_step;
            idx_d      = '0;
            tdata_d    = cfg_start_step;
            tvalid_d   = 1'b1;
            state_d    = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (m_axis_step_tready) begin
            tvalid_d = 1'b0;
            state_d  = ST_DWELL;
          end
        end
        ST_DWELL: begin
          if (timer_expired) begin
            state_d = ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (inc_sh_q == '0) begin
            tdata_d  = cur_q;
            tvalid_d = 1'b1;
            state_d  = ST_LOAD;
          end else if (overrun) begin
            if (loop_sh_q) begin
              cur_d    = start_sh_q;
              idx_d    = '0;
              tdata_d  = start_sh_q;
              tvalid_d = 1'b1;
              state_d  = ST_LOAD;
            end else begin
              // tdata keeps the last accepted step so the NCO holds its tone.
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end else begin
            cur_d    = step_sum[STEP_WIDTH-1:0];
            idx_d    = sat_inc(idx_q);
            tdata_d  = step_sum[STEP_WIDTH-1:0];
            tvalid_d = 1'b1;
            state_d  = ST_LOAD;
          end
        end
        ST_MUTE: begin
          if (m_axis_step_tready) begin
            tvalid_d = 1'b0;
            state_d  = ST_IDLE;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          tvalid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= ST_IDLE;
      start_sh_q <= '0;
      stop_sh_q  <= '0;
      inc_sh_q   <= '0;
      dwell_sh_q <= '0;
      loop_sh_q  <= 1'b0;
      cur_q      <= '0;
      idx_q      <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_sh_q <= start_sh_d;
      stop_sh_q  <= stop_sh_d;
      inc_sh_q   <= inc_sh_d;
      dwell_sh_q <= dwell_sh_d;
      loop_sh_q  <= loop_sh_d;
      cur_q      <= cur_d;
      idx_q      <= idx_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      done_q     <= done_d;
    end
  end

  assign m_axis_step_tdata  = tdata_q;
  assign m_axis_step_tvalid = tvalid_q;
  assign done               = done_q;
  assign step_index         = idx_q;
  assign busy               = (state_q == ST_LOAD) || (state_q == ST_DWELL) ||
                              (state_q == ST_NEXT) || (state_q == ST_MUTE);

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: a table of sweep plans with hand-computed handshake
// sequences, followed by directed sequences for backpressure, abort and reset.
module tb_nco_sweep_ctrl;

  logic        aclk = 1'b0;
  logic        arst_n = 1'b0;
  logic [31:0] cfg_start_step = '0;
  logic [31:0] cfg_stop_step = '0;
  logic [31:0] cfg_inc_step = '0;
  logic [23:0] cfg_dwell = '0;
  logic        cfg_loop = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready = 1'b1;
  logic        busy;
  logic        done;
  logic [15:0] step_index;

  nco_sweep_ctrl #(
    .STEP_WIDTH  (32),
    .DWELL_WIDTH (24),
    .IDX_WIDTH   (16)
  ) dut (
    .aclk               (aclk),
    .arst_n             (arst_n),
    .cfg_start_step     (cfg_start_step),
    .cfg_stop_step      (cfg_stop_step),
    .cfg_inc_step       (cfg_inc_step),
    .cfg_dwell          (cfg_dwell),
    .cfg_loop           (cfg_loop),
    .start              (start),
    .abort              (abort),
    .m_axis_step_tdata  (tdata),
    .m_axis_step_tvalid (tvalid),
    .m_axis_step_tready (tready),
    .busy               (busy),
    .done               (done),
    .step_index         (step_index)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // Handshake log, sampled on the falling edge; cyc+1 is the rising edge at
  // which the transfer actually happens.
  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [15:0] idx;
  } hs_t;
  hs_t hs_log[$];
  int  done_cnt = 0;
  int  done_busy_cnt = 0;

  always @(negedge aclk) begin
    if (arst_n && tvalid && tready) hs_log.push_back('{cyc: cyc + 1, data: tdata, idx: step_index});
    if (done) done_cnt <= done_cnt + 1;
    if (done && busy) done_busy_cnt <= done_busy_cnt + 1;
  end

  int checks = 0;
  int errors = 0;
  int cur_v  = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (case %0d): got %0h, expected %0h", name, cur_v, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic abort_to_idle();
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(2);
    chk("abort_idle_tvalid", tvalid, 0);
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_tdata", tdata, 0);
  endtask

  typedef struct {
    logic [31:0]      s;
    logic [31:0]      p;
    logic [31:0]      inc;
    logic [23:0]      dw;
    logic             lp;
    int               run;
    int               npts;
    int               period;
    logic [5:0][31:0] d;
    logic [5:0][15:0] ix;
    int               ndone;
    logic             busy_end;
    logic [31:0]      tdata_end;
    logic [15:0]      idx_end;
  } vec_t;

  localparam int NV = 6;
  vec_t vt [NV];

  initial begin
    int base;
    int dbase;
    int c0;
    int n;

    // Sweep plans. d[k]/ix[k] = data and index of the k-th handshake.
    // 0: 1..4 <<22, dwell 10, single shot; period 12, ends in DONE at index 3.
    vt[0] = '{s: 32'h0040_0000, p: 32'h0100_0000, inc: 32'h0040_0000, dw: 24'd10, lp: 1'b0,
              run: 54, npts: 4, period: 12, d: '0, ix: '0, ndone: 1, busy_end: 1'b0,
              tdata_end: 32'h0100_0000, idx_end: 16'd3};
    vt[0].d[0] = 32'h0040_0000; vt[0].d[1] = 32'h0080_0000;
    vt[0].d[2] = 32'h00C0_0000; vt[0].d[3] = 32'h0100_0000;
    vt[0].ix[0] = 16'd0; vt[0].ix[1] = 16'd1; vt[0].ix[2] = 16'd2; vt[0].ix[3] = 16'd3;
    // 1: same plan looping: wraps to START with index 0, never done.
    vt[1] = vt[0];
    vt[1].lp = 1'b1; vt[1].run = 66; vt[1].npts = 6; vt[1].ndone = 0; vt[1].busy_end = 1'b1;
    vt[1].d[4] = 32'h0040_0000; vt[1].d[5] = 32'h0080_0000;
    vt[1].ix[4] = 16'd0; vt[1].ix[5] = 16'd1;
    vt[1].tdata_end = 32'h0080_0000; vt[1].idx_end = 16'd1;
    // 2: step adder carries out of 32 bits: one point then DONE.
    vt[2] = '{s: 32'hFFFF_FF00, p: 32'hFFFF_FFFF, inc: 32'h0000_0200, dw: 24'd3, lp: 1'b0,
              run: 20, npts: 1, period: 0, d: '0, ix: '0, ndone: 1, busy_end: 1'b0,
              tdata_end: 32'hFFFF_FF00, idx_end: 16'd0};
    vt[2].d[0] = 32'hFFFF_FF00;
    // 3: START above STOP: START sent once, then DONE.
    vt[3] = '{s: 32'h0000_0500, p: 32'h0000_0100, inc: 32'h0000_0010, dw: 24'd2, lp: 1'b0,
              run: 20, npts: 1, period: 0, d: '0, ix: '0, ndone: 1, busy_end: 1'b0,
              tdata_end: 32'h0000_0500, idx_end: 16'd0};
    vt[3].d[0] = 32'h0000_0500;
    // 4: INC=0, DWELL=0: START re-sent every 3 clocks forever.
    vt[4] = '{s: 32'h0000_1234, p: 32'h0000_0000, inc: 32'h0, dw: 24'd0, lp: 1'b0,
              run: 14, npts: 5, period: 3, d: '0, ix: '0, ndone: 0, busy_end: 1'b1,
              tdata_end: 32'h0000_1234, idx_end: 16'd0};
    for (int k = 0; k < 5; k++) vt[4].d[k] = 32'h0000_1234;
    // 5: START above STOP while looping: START repeats, dwell 1 gives period 3.
    vt[5] = '{s: 32'h0000_0500, p: 32'h0000_0100, inc: 32'h0000_0010, dw: 24'd1, lp: 1'b1,
              run: 14, npts: 5, period: 3, d: '0, ix: '0, ndone: 0, busy_end: 1'b1,
              tdata_end: 32'h0000_0500, idx_end: 16'd0};
    for (int k = 0; k < 5; k++) vt[5].d[k] = 32'h0000_0500;

    // Reset state
    tick(2);
    chk("rst_tdata", tdata, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", step_index, 0);
    arst_n = 1'b1;
    tick(2);
    chk("idle_tvalid", tvalid, 0);

    // Table-driven sweeps
    for (int v = 0; v < NV; v++) begin
      cur_v = v;
      base  = hs_log.size();
      dbase = done_cnt;
      cfg_start_step = vt[v].s;
      cfg_stop_step  = vt[v].p;
      cfg_inc_step   = vt[v].inc;
      cfg_dwell      = vt[v].dw;
      cfg_loop       = vt[v].lp;
      tready         = 1'b1;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      c0 = cyc;
      tick(vt[v].run);
      n = hs_log.size() - base;
      chk("hs_count", n, vt[v].npts);
      if (n == vt[v].npts) begin
        for (int k = 0; k < n; k++) begin
          chk("hs_data", hs_log[base + k].data, vt[v].d[k]);
          chk("hs_idx", hs_log[base + k].idx, vt[v].ix[k]);
          if (k == 0) chk("hs_first_latency", hs_log[base].cyc - c0, 1);
          else chk("hs_period", hs_log[base + k].cyc - hs_log[base + k - 1].cyc, vt[v].period);
        end
      end
      chk("done_pulses", done_cnt - dbase, vt[v].ndone);
      chk("busy_end", busy, vt[v].busy_end);
      chk("tdata_end", tdata, vt[v].tdata_end);
      chk("idx_end", step_index, vt[v].idx_end);
      if (!vt[v].busy_end) chk("tvalid_end", tvalid, 0);
      abort_to_idle();
    end
    chk("done_with_busy", done_busy_cnt, 0);

    // Backpressure: tready low for 7 clocks in LOAD
    cur_v = 10;
    base  = hs_log.size();
    cfg_start_step = 32'h0040_0000;
    cfg_stop_step  = 32'h0100_0000;
    cfg_inc_step   = 32'h0040_0000;
    cfg_dwell      = 24'd10;
    cfg_loop       = 1'b0;
    tready = 1'b0;
    start  = 1'b1;
    tick(1);
    start  = 1'b0;
    c0 = cyc;
    for (int k = 0; k < 7; k++) begin
      tick(1);
      chk("bp_tvalid", tvalid, 1);
      chk("bp_tdata", tdata, 32'h0040_0000);
    end
    tready = 1'b1;
    tick(14);
    n = hs_log.size() - base;
    chk("bp_hs_count", n, 2);
    if (n == 2) begin
      chk("bp_accept_cycle", hs_log[base].cyc - c0, 8);
      chk("bp_period", hs_log[base + 1].cyc - hs_log[base].cyc, 12);
      chk("bp_second_data", hs_log[base + 1].data, 32'h0080_0000);
    end
    abort_to_idle();

    // Abort mid-DWELL with simultaneous start, MUTE held by backpressure
    cur_v = 11;
    dbase = done_cnt;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(5);
    abort  = 1'b1;
    start  = 1'b1;
    cfg_start_step = 32'h0000_AAAA;
    tready = 1'b0;
    tick(1);
    abort = 1'b0;
    start = 1'b0;
    chk("mute_busy", busy, 1);
    chk("mute_tvalid", tvalid, 1);
    chk("mute_tdata", tdata, 0);
    tick(3);
    chk("mute_hold_tvalid", tvalid, 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("mute_reabort_tvalid", tvalid, 1);
    chk("mute_reabort_tdata", tdata, 0);
    tready = 1'b1;
    tick(1);
    chk("mute_exit_busy", busy, 0);
    chk("mute_exit_tvalid", tvalid, 0);
    tick(3);
    chk("start_dropped_tvalid", tvalid, 0);
    chk("start_dropped_tdata", tdata, 0);
    chk("abort_no_done", done_cnt - dbase, 0);

    // Asynchronous reset mid-sweep
    cur_v = 12;
    dbase = done_cnt;
    cfg_start_step = 32'h0000_0100;
    cfg_stop_step  = 32'h0000_FFFF;
    cfg_inc_step   = 32'h0000_0100;
    cfg_dwell      = 24'd0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(8);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_idx", step_index, 2);
    #2;
    arst_n = 1'b0;
    #1;
    chk("arst_tdata", tdata, 0);
    chk("arst_tvalid", tvalid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_idx", step_index, 0);
    tick(2);
    arst_n = 1'b1;
    tick(3);
    chk("post_rst_tvalid", tvalid, 0);
    chk("post_rst_busy", busy, 0);
    chk("arst_no_done", done_cnt - dbase, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
